// File: rtl/vec_pkg.sv
// Shared types and constants for the vector-pipeline result path.
// Floats are carried as opaque 27-bit words; nothing here interprets them.
package vec_pkg;

  localparam int FP_W = 27;

  typedef struct packed {
    logic [FP_W-1:0] x;
    logic [FP_W-1:0] y;
    logic [FP_W-1:0] z;
  } vec3_t;

  localparam logic [FP_W-1:0] FP_ONE = 27'h1FC0000;
  localparam logic [FP_W-1:0] FP_TWO = 27'h2000000;

  function automatic vec3_t vec3(input logic [FP_W-1:0] x,
                                 input logic [FP_W-1:0] y,
                                 input logic [FP_W-1:0] z);
    vec3_t v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

endpackage

// File: rtl/vec_pipe_fifo.sv
// Synchronous FIFO with a registered show-ahead head: the head register refills
// from the circular buffer whenever it is empty or being popped.
module vec_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             head_vld_q, head_vld_d;
  logic [WIDTH-1:0] head_q;

  logic mem_empty, mem_full, wr_fire, rd_pop, head_load;

  always_comb begin
    mem_empty  = (wr_ptr_q == rd_ptr_q);
    mem_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_fire    = i_wr_en && !mem_full;
    rd_pop     = head_vld_q && i_rd_ready;
    head_load  = !mem_empty && (!head_vld_q || rd_pop);
    wr_ptr_d   = wr_fire   ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = head_load ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    head_vld_d = head_vld_q;
    if (head_load) begin
      head_vld_d = 1'b1;
    end else if (rd_pop) begin
      head_vld_d = 1'b0;
    end
  end

  // Buffer contents are never reset; only the pointers define occupancy.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      head_vld_q <= head_vld_d;
      if (head_load) begin
        head_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

  assign o_rd_valid = head_vld_q;
  assign o_rd_data  = head_q;

endmodule

// File: rtl/vec_pipe_drain.sv
// Result-side companion for fixed-latency vector pipelines: tracks issued ops in a
// valid/tag delay line, captures results on their cycle, and throttles issue by credit.
module vec_pipe_drain
  import vec_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 10
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [TAG_W-1:0]           i_in_tag,
  input  logic [FP_W-1:0]            i_res_x,
  input  logic [FP_W-1:0]            i_res_y,
  input  logic [FP_W-1:0]            i_res_z,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [FP_W-1:0]            o_out_x,
  output logic [FP_W-1:0]            o_out_y,
  output logic [FP_W-1:0]            o_out_z,
  output logic [TAG_W-1:0]           o_out_tag,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int RES_W = TAG_W + $bits(vec3_t);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    vec3_t            v;
  } res_t;

  logic [LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [TAG_W-1:0]   dl_tag_q [LATENCY];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               issue, pop, capture;
  res_t               wr_res, head_res;

  // Credits cover in-flight plus buffered ops, so a capture always finds room.
  assign o_in_ready = (count_q < CNT_W'(DEPTH));
  assign issue      = i_in_valid && o_in_ready;
  assign pop        = o_out_valid && i_out_ready;
  assign capture    = dl_vld_q[LATENCY-1];

  always_comb begin
    dl_vld_d    = '0;
    dl_vld_d[0] = issue;
    for (int i = 1; i < LATENCY; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
    end
    count_d = count_q;
    case ({issue, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dl_vld_q <= '0;
      count_q  <= '0;
    end else begin
      dl_vld_q <= dl_vld_d;
      count_q  <= count_d;
    end
  end

  // Tags ride alongside the valid bits; only the valid bit decides a capture.
  always_ff @(posedge i_clk) begin
    dl_tag_q[0] <= i_in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      dl_tag_q[i] <= dl_tag_q[i-1];
    end
  end

  assign wr_res.tag = dl_tag_q[LATENCY-1];
  assign wr_res.v   = vec3(i_res_x, i_res_y, i_res_z);

  vec_pipe_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (capture),
    .i_wr_data  (wr_res),
    .o_rd_valid (o_out_valid),
    .i_rd_ready (i_out_ready),
    .o_rd_data  (head_res)
  );

  assign o_out_tag = head_res.tag;
  assign o_out_x   = head_res.v.x;
  assign o_out_y   = head_res.v.y;
  assign o_out_z   = head_res.v.z;
  assign o_count   = count_q;

endmodule

// File: tb/tb_vec_pipe_drain.sv
// Scoreboard bench for vec_pipe_drain: a queue-of-due-times model predicts every
// captured result; a monitor compares each popped head and the credit state.
module tb_vec_pipe_drain;
  import vec_pkg::*;

  localparam int LAT = 4;
  localparam int DEP = 16;
  localparam int TW  = 10;
  localparam int CW  = $clog2(DEP+1);

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_in_valid = 1'b0;
  logic            o_in_ready;
  logic [TW-1:0]   i_in_tag = '0;
  logic [FP_W-1:0] i_res_x = '0, i_res_y = '0, i_res_z = '0;
  logic            o_out_valid;
  logic            i_out_ready = 1'b0;
  logic [FP_W-1:0] o_out_x, o_out_y, o_out_z;
  logic [TW-1:0]   o_out_tag;
  logic [CW-1:0]   o_count;

  vec_pipe_drain #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(TW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_tag    (i_in_tag),
    .i_res_x     (i_res_x),
    .i_res_y     (i_res_y),
    .i_res_z     (i_res_z),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_x     (o_out_x),
    .o_out_y     (o_out_y),
    .o_out_z     (o_out_z),
    .o_out_tag   (o_out_tag),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int            due;
    logic [TW-1:0] tag;
  } pend_t;

  typedef struct packed {
    logic [TW-1:0]   tag;
    logic [FP_W-1:0] x;
    logic [FP_W-1:0] y;
    logic [FP_W-1:0] z;
  } item_t;

  pend_t pend_q[$];
  item_t exp_q[$];
  int    mcount, edge_n, n_checks, n_pass;
  bit    res_rand = 1'b1;
  bit    hold_f;
  item_t hold_v, got_m;
  bit    pop_m, iss_m;
  bit    thr_on;
  int    thr_pops, thr_first, thr_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: each accepted issue is due for capture LAT edges later.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q.delete();
      exp_q.delete();
      mcount = 0;
      hold_f = 1'b0;
    end else begin
      edge_n++;
      pop_m = o_out_valid && i_out_ready;
      iss_m = i_in_valid && (mcount < DEP);
      got_m = {o_out_tag, o_out_x, o_out_y, o_out_z};
      if (pop_m) begin
        if (exp_q.size() == 0) chk("pop_with_empty_model", 128'(exp_q.size()), 128'(1));
        else chk("out_item", 128'(got_m), 128'(exp_q.pop_front()));
        if (thr_on) begin
          if (thr_pops == 0) thr_first = edge_n;
          thr_last = edge_n;
          thr_pops++;
        end
      end
      if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
        exp_q.push_back({pend_q[0].tag, i_res_x, i_res_y, i_res_z});
        void'(pend_q.pop_front());
      end
      if (iss_m) pend_q.push_back('{edge_n + LAT, i_in_tag});
      mcount = mcount + int'(iss_m) - int'(pop_m);
      hold_f = o_out_valid && !i_out_ready;
      hold_v = got_m;
    end
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("count", 128'(o_count), 128'(mcount));
      chk("in_ready", 128'(o_in_ready), 128'(mcount < DEP));
      if (o_out_valid) chk("valid_has_expected", 128'(exp_q.size() > 0), 128'(1));
      if (hold_f) begin
        chk("hold_valid", 128'(o_out_valid), 128'(1));
        chk("hold_data", 128'({o_out_tag, o_out_x, o_out_y, o_out_z}), 128'(hold_v));
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
    if (res_rand) begin
      i_res_x = FP_W'($urandom);
      i_res_y = FP_W'($urandom);
      i_res_z = FP_W'($urandom);
    end
  endtask

  task automatic drain(input string name);
    i_out_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (o_count == 0 && !o_out_valid) break;
      tick();
    end
    chk(name, 128'(o_count == 0 && !o_out_valid), 128'(1));
    i_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  t, t0;
    bit  found;

    // Reset held with random inputs, released off-edge.
    i_rst_n = 1'b0;
    repeat (6) begin
      tick();
      i_in_valid  = 1'($urandom);
      i_out_ready = 1'($urandom);
      i_in_tag    = TW'($urandom);
    end
    tick();
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    #2 i_rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 128'(o_in_ready), 128'(1));
    chk("rst_out_valid", 128'(o_out_valid), 128'(0));
    chk("rst_count", 128'(o_count), 128'(0));
    chk("rst_out_x", 128'(o_out_x), 128'(0));
    chk("rst_out_y", 128'(o_out_y), 128'(0));
    chk("rst_out_z", 128'(o_out_z), 128'(0));
    chk("rst_out_tag", 128'(o_out_tag), 128'(0));

    // Single op with scalar result.
    res_rand = 1'b0;
    i_res_x  = FP_ONE;
    i_res_y  = '0;
    i_res_z  = '0;
    tick();
    t = edge_n + 1;
    i_in_valid = 1'b1;
    i_in_tag   = TW'(5);
    tick();
    i_in_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("single_seen", 128'(found), 128'(1));
    chk("single_latency", 128'(edge_n), 128'(t + LAT + 1));
    chk("single_tag", 128'(o_out_tag), 128'(5));
    chk("single_x", 128'(o_out_x), 128'(FP_ONE));
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    chk("single_count_after_pop", 128'(o_count), 128'(0));
    chk("single_valid_after_pop", 128'(o_out_valid), 128'(0));
    res_rand = 1'b1;

    // Backpressure: continuous issue into a stalled consumer.
    tick();
    for (int k = 0; k < 25; k++) begin
      i_in_valid = 1'b1;
      i_in_tag   = TW'(k);
      tick();
    end
    i_in_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("bp_count_full", 128'(o_count), 128'(DEP));
    chk("bp_ready_low", 128'(o_in_ready), 128'(0));
    chk("bp_head_tag", 128'(o_out_tag), 128'(0));
    i_out_ready = 1'b1;
    tick();
    chk("bp_ready_after_first_pop", 128'(o_in_ready), 128'(1));
    drain("bp_drained");

    // Simultaneous issue and pop at count DEP-1.
    tick();
    for (int k = 0; k < DEP - 1; k++) begin
      i_in_valid = 1'b1;
      i_in_tag   = TW'(100 + k);
      tick();
    end
    i_in_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("sim_count_before", 128'(o_count), 128'(DEP - 1));
    i_in_valid  = 1'b1;
    i_in_tag    = TW'(200);
    i_out_ready = 1'b1;
    tick();
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    chk("sim_count_after", 128'(o_count), 128'(DEP - 1));
    chk("sim_ready_after", 128'(o_in_ready), 128'(1));
    drain("sim_drained");

    // Asynchronous reset with 2 buffered and 3 in flight.
    tick();
    for (int k = 0; k < 2; k++) begin
      i_in_valid = 1'b1;
      i_in_tag   = TW'($urandom);
      tick();
    end
    i_in_valid = 1'b0;
    repeat (LAT + 3) tick();
    chk("mid_buffered", 128'(o_count), 128'(2));
    for (int k = 0; k < 3; k++) begin
      i_in_valid = 1'b1;
      i_in_tag   = TW'($urandom);
      tick();
    end
    i_in_valid = 1'b0;
    #1 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(o_out_valid), 128'(0));
    chk("mid_rst_count", 128'(o_count), 128'(0));
    chk("mid_rst_ready", 128'(o_in_ready), 128'(1));
    #1 i_rst_n = 1'b1;
    repeat (LAT + 3) tick();
    chk("mid_after_valid", 128'(o_out_valid), 128'(0));
    chk("mid_after_count", 128'(o_count), 128'(0));

    // Throughput: 100 back-to-back issues with a always-ready consumer.
    i_out_ready = 1'b1;
    tick();
    thr_on = 1'b1;
    t0 = edge_n + 1;
    for (int k = 0; k < 100; k++) begin
      i_in_valid = 1'b1;
      i_in_tag   = TW'(k);
      tick();
    end
    i_in_valid = 1'b0;
    repeat (LAT + 6) tick();
    thr_on = 1'b0;
    chk("thr_pops", 128'(thr_pops), 128'(100));
    chk("thr_first_pop_edge", 128'(thr_first), 128'(t0 + LAT + 2));
    chk("thr_last_pop_edge", 128'(thr_last), 128'(t0 + 99 + LAT + 2));
    drain("thr_drained");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
